// File: rtl/axi_mem_arbiter_if.sv
// AXI4 channel bundle shared by the IFU, LSU and downstream memory port.
// 32-bit address/data, 4-bit IDs; master drives requests, slave drives responses.
interface axi_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awid;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
               awvalid, awaddr, awlen, awsize, awburst, awid,
               wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rlast, rid,
               awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
               awvalid, awaddr, awlen, awsize, awburst, awid,
               wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rlast, rid,
               awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Shares one downstream AXI port between the IFU (reads) and LSU (reads/writes), one whole
// transaction at a time. Define ARB_ROUND_ROBIN_EN to alternate IFU/LSU priority on each grant.
module axi_mem_arbiter #(
    parameter logic [3:0]  IFU_ID    = 4'd0,
    parameter logic [3:0]  LSU_ID    = 4'd1,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    axi_if.slave       ifu,
    axi_if.slave       lsu,
    axi_if.master      mem,
    output logic       busy,
    output logic [1:0] owner
);
    localparam int unsigned CNT_W = $clog2(BURST_MAX) + 1;

    // Encoding doubles as the owner code.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFU_RD = 2'd1;
    localparam logic [1:0] LSU_RD = 2'd2;
    localparam logic [1:0] LSU_WR = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             ar_done_q, aw_done_q, w_done_q;
    logic [7:0]       arlen_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic sel_ifu, sel_lsu_rd, rd_active, wr_active;
    logic own_arvalid, own_rready;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic cnt_hit, r_last;
    logic lsu_req, pick_ifu;

    assign sel_ifu    = (state_q == IFU_RD);
    assign sel_lsu_rd = (state_q == LSU_RD);
    assign rd_active  = sel_ifu | sel_lsu_rd;
    assign wr_active  = (state_q == LSU_WR);

    assign busy  = (state_q != IDLE);
    assign owner = state_q;

    assign own_arvalid = sel_ifu ? ifu.arvalid : lsu.arvalid;
    assign own_rready  = sel_ifu ? ifu.rready  : lsu.rready;

    // Read address/data path; ar_done_q stops a second AR leaking into the same grant.
    assign mem.arvalid = rd_active & ~ar_done_q & own_arvalid;
    assign mem.araddr  = sel_ifu ? ifu.araddr  : lsu.araddr;
    assign mem.arlen   = sel_ifu ? ifu.arlen   : lsu.arlen;
    assign mem.arsize  = sel_ifu ? ifu.arsize  : lsu.arsize;
    assign mem.arburst = sel_ifu ? ifu.arburst : lsu.arburst;
    assign mem.arid    = sel_ifu ? IFU_ID      : LSU_ID;
    assign mem.rready  = rd_active & own_rready;

    assign ar_hs   = mem.arvalid & mem.arready;
    assign r_hs    = mem.rvalid & mem.rready;
    assign cnt_hit = ar_done_q & (8'(beat_cnt_q) == arlen_q);
    assign r_last  = mem.rlast | cnt_hit;

    assign ifu.arready = sel_ifu & ~ar_done_q & mem.arready;
    assign ifu.rvalid  = sel_ifu & mem.rvalid;
    assign ifu.rdata   = mem.rdata;
    assign ifu.rresp   = mem.rresp;
    assign ifu.rlast   = r_last;
    assign ifu.rid     = mem.rid;
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;
    assign ifu.bresp   = 2'b00;
    assign ifu.bid     = 4'd0;

    assign lsu.arready = sel_lsu_rd & ~ar_done_q & mem.arready;
    assign lsu.rvalid  = sel_lsu_rd & mem.rvalid;
    assign lsu.rdata   = mem.rdata;
    assign lsu.rresp   = mem.rresp;
    assign lsu.rlast   = r_last;
    assign lsu.rid     = mem.rid;

    // Write path: AW and W complete independently, B closes the grant.
    assign mem.awvalid = wr_active & ~aw_done_q & lsu.awvalid;
    assign mem.awaddr  = lsu.awaddr;
    assign mem.awlen   = lsu.awlen;
    assign mem.awsize  = lsu.awsize;
    assign mem.awburst = lsu.awburst;
    assign mem.awid    = LSU_ID;
    assign mem.wvalid  = wr_active & ~w_done_q & lsu.wvalid;
    assign mem.wdata   = lsu.wdata;
    assign mem.wstrb   = lsu.wstrb;
    assign mem.wlast   = lsu.wlast;
    assign mem.bready  = wr_active & lsu.bready;

    assign lsu.awready = wr_active & ~aw_done_q & mem.awready;
    assign lsu.wready  = wr_active & ~w_done_q & mem.wready;
    assign lsu.bvalid  = wr_active & mem.bvalid;
    assign lsu.bresp   = mem.bresp;
    assign lsu.bid     = mem.bid;

    assign aw_hs = mem.awvalid & mem.awready;
    assign w_hs  = mem.wvalid & mem.wready;
    assign b_hs  = mem.bvalid & mem.bready;

    assign lsu_req = lsu.awvalid | lsu.arvalid;

`ifdef ARB_ROUND_ROBIN_EN
    // 0: LSU wins the next IFU/LSU tie; toggles on every grant.
    logic last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d != IDLE)) begin
            last_grant_q <= ~last_grant_q;
        end
    end

    assign pick_ifu = ifu.arvalid & (~lsu_req | last_grant_q);
`else
    assign pick_ifu = ifu.arvalid & ~lsu_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_ifu)         state_d = IFU_RD;
                else if (lsu.awvalid) state_d = LSU_WR;
                else if (lsu.arvalid) state_d = LSU_RD;
            end
            IFU_RD, LSU_RD: if (r_hs && r_last) state_d = IDLE;
            LSU_WR:         if (b_hs)           state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ar_done_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            arlen_q    <= 8'd0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == IDLE) begin
                ar_done_q  <= 1'b0;
                aw_done_q  <= 1'b0;
                w_done_q   <= 1'b0;
                beat_cnt_q <= '0;
            end else begin
                if (ar_hs) begin
                    ar_done_q <= 1'b1;
                    arlen_q   <= mem.arlen;
                end
                if (r_hs)                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                if (aw_hs)               aw_done_q  <= 1'b1;
                if (w_hs && mem.wlast)   w_done_q   <= 1'b1;
            end
        end
    end

`ifndef __SYNTHESIS__
    always_ff @(posedge clk) begin
        if (!rst && r_hs && (mem.rid != mem.arid))
            $error("axi_mem_arbiter: rid %0h does not match owner id %0h", mem.rid, mem.arid);
        if (!rst && b_hs && (mem.bid != LSU_ID))
            $error("axi_mem_arbiter: bid %0h does not match LSU id %0h", mem.bid, LSU_ID);
    end
`endif

    logic unused_inputs;
    assign unused_inputs = ^{ifu.awvalid, ifu.awaddr, ifu.awlen, ifu.awsize, ifu.awburst,
                             ifu.awid, ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast,
                             ifu.bready, ifu.arid, lsu.arid, lsu.awid, mem.rid, mem.bid};
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a transaction-level ownership model checked every cycle
// plus literal expectations for each scenario.
module tb_axi_mem_arbiter;
    localparam logic [3:0] IFU_ID = 4'd0;
    localparam logic [3:0] LSU_ID = 4'd1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [1:0] owner;

    always #5 clk = ~clk;

    axi_if ifu_bus();
    axi_if lsu_bus();
    axi_if mem_bus();

    axi_mem_arbiter #(
        .IFU_ID   (IFU_ID),
        .LSU_ID   (LSU_ID),
        .BURST_MAX(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ifu  (ifu_bus),
        .lsu  (lsu_bus),
        .mem  (mem_bus),
        .busy (busy),
        .owner(owner)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ownership model: who holds the port, derived from the bench-driven request/response traffic.
    int m_owner    = 0;
    int m_beats    = 0;
    int m_arlen    = 0;
    bit m_ar_seen  = 0;
    bit m_ifu_turn = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner    <= 0;
            m_beats    <= 0;
            m_ar_seen  <= 0;
            m_ifu_turn <= 0;
        end else if (m_owner == 0) begin
            if ((lsu_bus.awvalid || lsu_bus.arvalid) && !(ifu_bus.arvalid && m_ifu_turn))
                m_owner <= lsu_bus.awvalid ? 3 : 2;
            else if (ifu_bus.arvalid)
                m_owner <= 1;
`ifdef ARB_ROUND_ROBIN_EN
            if (lsu_bus.awvalid || lsu_bus.arvalid || ifu_bus.arvalid)
                m_ifu_turn <= !m_ifu_turn;
`endif
        end else if (m_owner == 3) begin
            if (mem_bus.bvalid && lsu_bus.bready) m_owner <= 0;
        end else begin
            if (!m_ar_seen && mem_bus.arready &&
                (m_owner == 1 ? ifu_bus.arvalid : lsu_bus.arvalid)) begin
                m_ar_seen <= 1;
                m_arlen   <= int'(m_owner == 1 ? ifu_bus.arlen : lsu_bus.arlen);
            end
            if (mem_bus.rvalid && (m_owner == 1 ? ifu_bus.rready : lsu_bus.rready)) begin
                // A burst ends on rlast or once arlen+1 beats have been delivered.
                if (mem_bus.rlast || (m_ar_seen && m_beats + 1 == m_arlen + 1)) begin
                    m_owner   <= 0;
                    m_beats   <= 0;
                    m_ar_seen <= 0;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("owner", owner, m_owner);
        chk("busy", busy, m_owner != 0);
        chk("ifu_rvalid", ifu_bus.rvalid, (m_owner == 1) ? mem_bus.rvalid : 1'b0);
        chk("lsu_rvalid", lsu_bus.rvalid, (m_owner == 2) ? mem_bus.rvalid : 1'b0);
        chk("lsu_bvalid", lsu_bus.bvalid, (m_owner == 3) ? mem_bus.bvalid : 1'b0);
        chk("ifu_arready_gate", ifu_bus.arready & (m_owner != 1), 0);
        chk("lsu_arready_gate", lsu_bus.arready & (m_owner != 2), 0);
        chk("lsu_wr_ready_gate", {lsu_bus.awready, lsu_bus.wready} & {2{m_owner != 3}}, 0);
        chk("mem_rready", mem_bus.rready,
            (m_owner == 1) ? ifu_bus.rready : (m_owner == 2) ? lsu_bus.rready : 1'b0);
        chk("mem_bready", mem_bus.bready, (m_owner == 3) ? lsu_bus.bready : 1'b0);
        if (m_owner == 0)
            chk("idle_quiet", {mem_bus.arvalid, mem_bus.awvalid, mem_bus.wvalid}, 0);
        if (mem_bus.arvalid) chk("arid", mem_bus.arid, (m_owner == 2) ? LSU_ID : IFU_ID);
        if (ifu_bus.rvalid)  chk("ifu_rdata", ifu_bus.rdata, mem_bus.rdata);
        if (lsu_bus.rvalid)  chk("lsu_rdata", lsu_bus.rdata, mem_bus.rdata);
        if (lsu_bus.bvalid)  chk("lsu_bresp", lsu_bus.bresp, mem_bus.bresp);
    end

    task automatic idle_inputs();
        ifu_bus.arvalid = 0; ifu_bus.araddr = 0; ifu_bus.arlen = 0; ifu_bus.arsize = 3'd2;
        ifu_bus.arburst = 2'd1; ifu_bus.arid = 0; ifu_bus.rready = 0;
        ifu_bus.awvalid = 0; ifu_bus.awaddr = 0; ifu_bus.awlen = 0; ifu_bus.awsize = 0;
        ifu_bus.awburst = 0; ifu_bus.awid = 0; ifu_bus.wvalid = 0; ifu_bus.wdata = 0;
        ifu_bus.wstrb = 0; ifu_bus.wlast = 0; ifu_bus.bready = 0;
        lsu_bus.arvalid = 0; lsu_bus.araddr = 0; lsu_bus.arlen = 0; lsu_bus.arsize = 3'd2;
        lsu_bus.arburst = 2'd1; lsu_bus.arid = 0; lsu_bus.rready = 0;
        lsu_bus.awvalid = 0; lsu_bus.awaddr = 0; lsu_bus.awlen = 0; lsu_bus.awsize = 3'd2;
        lsu_bus.awburst = 2'd1; lsu_bus.awid = 0; lsu_bus.wvalid = 0; lsu_bus.wdata = 0;
        lsu_bus.wstrb = 0; lsu_bus.wlast = 0; lsu_bus.bready = 0;
        mem_bus.arready = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0; mem_bus.rresp = 0;
        mem_bus.rlast = 0; mem_bus.rid = 0; mem_bus.awready = 0; mem_bus.wready = 0;
        mem_bus.bvalid = 0; mem_bus.bresp = 0; mem_bus.bid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    int exp_grant[4];

    initial begin
        idle_inputs();
        #1 rst = 1;
        #1;
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_valids", {mem_bus.arvalid, mem_bus.awvalid, mem_bus.wvalid,
                               mem_bus.rready, mem_bus.bready}, 0);
        chk("rst_req_outs", {ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.rvalid,
                             lsu_bus.awready, lsu_bus.wready, lsu_bus.bvalid}, 0);
        do_reset();

        // Single IFU read.
        tick();
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_0000; ifu_bus.arlen = 0;
        ifu_bus.rready = 1; mem_bus.arready = 1;
        #1;
        chk("t1_grant_latency", {owner, mem_bus.arvalid, ifu_bus.arready}, 0);
        tick();
        chk("t1_owner", owner, 1);
        chk("t1_arvalid", mem_bus.arvalid, 1);
        chk("t1_araddr", mem_bus.araddr, 32'h8000_0000);
        chk("t1_arid", mem_bus.arid, 0);
        chk("t1_arready", ifu_bus.arready, 1);
        tick();
        ifu_bus.arvalid = 0; mem_bus.arready = 0;
        tick();
        mem_bus.rvalid = 1; mem_bus.rdata = 32'h0000_0413; mem_bus.rlast = 1; mem_bus.rid = 0;
        #1;
        chk("t1_rvalid", ifu_bus.rvalid, 1);
        chk("t1_rdata", ifu_bus.rdata, 32'h0000_0413);
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0;
        #1;
        chk("t1_back_idle", owner, 0);

        // IFU 4-beat INCR burst with a stall before beat 3.
        tick();
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'ha000_0000; ifu_bus.arlen = 8'd3;
        mem_bus.arready = 1;
        tick();
        chk("t2_owner", owner, 1);
        chk("t2_arlen", mem_bus.arlen, 3);
        tick();
        ifu_bus.arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                mem_bus.rvalid = 0;
                tick();
            end
            mem_bus.rvalid = 1; mem_bus.rdata = 32'h1111_0000 + i; mem_bus.rlast = (i == 3);
            #1;
            chk("t2_rvalid", ifu_bus.rvalid, 1);
            chk("t2_rdata", ifu_bus.rdata, 32'h1111_0000 + i);
            chk("t2_lsu_rvalid", lsu_bus.rvalid, 0);
            if (i == 3) chk("t2_beat_cnt", dut.beat_cnt_q, 3);
            tick();
        end
        mem_bus.rvalid = 0; mem_bus.rlast = 0;
        #1;
        chk("t2_back_idle", owner, 0);

        // arlen=1 burst that never sees rlast: ends on the beat count.
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'ha000_0100; ifu_bus.arlen = 8'd1;
        tick();
        tick();
        ifu_bus.arvalid = 0;
        mem_bus.rvalid = 1; mem_bus.rdata = 32'h2222_0000;
        #1;
        chk("t2b_beat0_rlast", ifu_bus.rlast, 0);
        tick();
        mem_bus.rdata = 32'h2222_0001;
        #1;
        chk("t2b_beat1_rlast", ifu_bus.rlast, 1);
        tick();
        mem_bus.rvalid = 0;
        #1;
        chk("t2b_back_idle", owner, 0);

        // Simultaneous LSU and IFU reads: LSU first, IFU after completion plus one idle cycle.
        do_reset();
        lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h0000_1000; lsu_bus.arlen = 0; lsu_bus.rready = 1;
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h0000_2000; ifu_bus.arlen = 0;
        mem_bus.arready = 1;
        tick();
        chk("t3_lsu_first", owner, 2);
        chk("t3_arid", mem_bus.arid, LSU_ID);
        chk("t3_araddr", mem_bus.araddr, 32'h0000_1000);
        chk("t3_ifu_arready", ifu_bus.arready, 0);
        tick();
        lsu_bus.arvalid = 0;
        #1;
        chk("t3_no_second_ar", mem_bus.arvalid, 0);
        tick();
        mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rid = LSU_ID; mem_bus.rdata = 32'h55;
        #1;
        chk("t3_lsu_rvalid", lsu_bus.rvalid, 1);
        chk("t3_ifu_rvalid", ifu_bus.rvalid, 0);
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0; mem_bus.rid = 0;
        #1;
        chk("t3_idle_gap", owner, 0);
        tick();
        chk("t3_ifu_owner", owner, 1);
        chk("t3_ifu_araddr", mem_bus.araddr, 32'h0000_2000);
        chk("t3_ifu_arid", mem_bus.arid, IFU_ID);
        tick();
        ifu_bus.arvalid = 0;
        mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rdata = 32'h66;
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0;

        // LSU write, AW two cycles ahead of W, SLVERR response; IFU read kept pending.
        lsu_bus.awvalid = 1; lsu_bus.awaddr = 32'h0000_3000; lsu_bus.awlen = 0;
        lsu_bus.bready = 1;
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'ha000_0040; ifu_bus.arlen = 8'd3;
        mem_bus.arready = 1; mem_bus.awready = 1; mem_bus.wready = 1;
        #1;
        chk("t4_pre_owner", owner, 0);
        tick();
        chk("t4_owner", owner, 3);
        chk("t4_awvalid", mem_bus.awvalid, 1);
        chk("t4_awid", mem_bus.awid, LSU_ID);
        chk("t4_awaddr", mem_bus.awaddr, 32'h0000_3000);
        chk("t4_awready", lsu_bus.awready, 1);
        chk("t4_ifu_arready", ifu_bus.arready, 0);
        chk("t4_mem_arvalid", mem_bus.arvalid, 0);
        tick();
        lsu_bus.awvalid = 0;
        #1;
        chk("t4_aw_once", mem_bus.awvalid, 0);
        tick();
        lsu_bus.wvalid = 1; lsu_bus.wdata = 32'hdead_beef; lsu_bus.wstrb = 4'hf; lsu_bus.wlast = 1;
        #1;
        chk("t4_wvalid", mem_bus.wvalid, 1);
        chk("t4_wdata", mem_bus.wdata, 32'hdead_beef);
        chk("t4_wready", lsu_bus.wready, 1);
        tick();
        lsu_bus.wvalid = 0; lsu_bus.wlast = 0;
        mem_bus.bvalid = 1; mem_bus.bresp = 2'b10; mem_bus.bid = LSU_ID;
        #1;
        chk("t4_bvalid", lsu_bus.bvalid, 1);
        chk("t4_bresp", lsu_bus.bresp, 2'b10);
        chk("t4_owner_hold", owner, 3);
        chk("t4_ifu_arready_b", ifu_bus.arready, 0);
        tick();
        mem_bus.bvalid = 0; mem_bus.bresp = 0; mem_bus.bid = 0;
        #1;
        chk("t4_done", owner, 0);
        tick();
        chk("t4_ifu_granted", owner, 1);
        chk("t4_ifu_araddr", mem_bus.araddr, 32'ha000_0040);

        // Reset pulsed at beat 2 of the IFU burst.
        tick();
        ifu_bus.arvalid = 0;
        mem_bus.rvalid = 1; mem_bus.rdata = 32'hb1; mem_bus.rlast = 0;
        #1;
        chk("t5_beat1", ifu_bus.rvalid, 1);
        tick();
        mem_bus.rdata = 32'hb2;
        rst = 1;
        #1;
        chk("t5_rst_owner", owner, 0);
        chk("t5_rst_valids", {mem_bus.arvalid, mem_bus.awvalid, mem_bus.wvalid, mem_bus.rready,
                              ifu_bus.rvalid, lsu_bus.rvalid, lsu_bus.bvalid}, 0);
        tick();
        rst = 0;
        mem_bus.rvalid = 0;
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h8000_0100; ifu_bus.arlen = 0;
        #1;
        chk("t5_post_rst_idle", owner, 0);
        tick();
        chk("t5_regrant", owner, 1);
        chk("t5_araddr", mem_bus.araddr, 32'h8000_0100);
        tick();
        ifu_bus.arvalid = 0;
        mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rdata = 32'h777;
        #1;
        chk("t5_rdata", ifu_bus.rdata, 32'h777);
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0;
        #1;
        chk("t5_back_idle", owner, 0);

        // LSU reads held back to back while the IFU keeps requesting.
`ifdef ARB_ROUND_ROBIN_EN
        exp_grant = '{2, 1, 2, 1};
`else
        exp_grant = '{2, 2, 2, 2};
`endif
        do_reset();
        lsu_bus.arvalid = 1; lsu_bus.araddr = 32'h0000_4000; lsu_bus.arlen = 0;
        ifu_bus.arvalid = 1; ifu_bus.araddr = 32'h0000_5000; ifu_bus.arlen = 0;
        mem_bus.arready = 1;
        for (int g = 0; g < 4; g++) begin
            int n = 0;
            while (owner == 0 && n < 10) begin
                tick();
                n++;
            end
            chk("rr_grant_wait", n < 10, 1);
            chk("rr_grant", owner, exp_grant[g]);
            tick();
            mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rdata = 32'h9000 + g;
            mem_bus.rid = (exp_grant[g] == 1) ? IFU_ID : LSU_ID;
            tick();
            mem_bus.rvalid = 0; mem_bus.rlast = 0;
        end

        idle_inputs();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
